// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART core.
package uart_pkg;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Frame states shared by the transmitter and the receiver
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } uart_state_t;

  // Number of sysclk cycles per line bit (integer division)
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO; head is presented from the registered storage.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // One extra pointer bit distinguishes full from empty on wrap-around
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Pointer update
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: TX/RX frame engines, each fed by its own FWFT FIFO, plus sticky error flags.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic                 UART_TX,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 tx_busy,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 err_clear
);

  localparam int   CPB        = clks_per_bit(CLK_HZ, BAUD);
  localparam int   HALF       = CPB / 2;
  localparam int   STOP_CLKS  = STOP_BITS * CPB;
  localparam int   CNT_W      = $clog2(STOP_CLKS + 1);
  localparam logic PAR_INV    = (PARITY == PAR_ODD);
  localparam bit   HAS_PARITY = (PARITY != PAR_NONE);

  // ---------------- transmitter ----------------
  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  uart_state_t          tx_state_reg;
  logic [CNT_W-1:0]     tx_cnt_reg;
  logic [3:0]           tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg, tx_line_reg;
  logic                 tx_bit_end, tx_stop_end;

  assign tx_bit_end  = (tx_cnt_reg == CNT_W'(CPB - 1));
  assign tx_stop_end = (tx_cnt_reg == CNT_W'(STOP_CLKS - 1));
  // Fetch the next byte when idle, or at the end of STOP so frames run back to back
  assign tx_pop   = !tx_empty && ((tx_state_reg == S_IDLE) ||
                                  (tx_state_reg == S_STOP && tx_stop_end));
  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_state_reg != S_IDLE) || !tx_empty;
  assign UART_TX  = tx_line_reg;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(sysclk), .srst(reset), .push_data(tx_data), .push(tx_valid && !tx_full),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // TX frame sequencer; the line is a registered output updated with each state change
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_state_reg <= S_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_line_reg  <= 1'b1;
    end else begin
      case (tx_state_reg)
        S_IDLE: begin
          tx_line_reg <= 1'b1;
          tx_cnt_reg  <= '0;
          if (tx_pop) begin
            tx_shift_reg <= tx_head;
            tx_par_reg   <= (^tx_head) ^ PAR_INV;
            tx_line_reg  <= 1'b0;
            tx_state_reg <= S_START;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_line_reg  <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_state_reg <= S_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 4'(DATA_BITS - 1)) begin
              tx_line_reg  <= HAS_PARITY ? tx_par_reg : 1'b1;
              tx_state_reg <= HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 4'd1;
              tx_line_reg  <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (tx_bit_end) begin
            tx_cnt_reg   <= '0;
            tx_line_reg  <= 1'b1;
            tx_state_reg <= S_STOP;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (tx_stop_end) begin
            tx_cnt_reg <= '0;
            if (tx_pop) begin
              tx_shift_reg <= tx_head;
              tx_par_reg   <= (^tx_head) ^ PAR_INV;
              tx_line_reg  <= 1'b0;
              tx_state_reg <= S_START;
            end else begin
              tx_state_reg <= S_IDLE;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          tx_state_reg <= S_IDLE;
          tx_line_reg  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
  uart_state_t          rx_state_reg;
  logic [CNT_W-1:0]     rx_cnt_reg;
  logic [3:0]           rx_bit_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_full, rx_empty, rx_sample, rx_push;
  logic                 set_overrun, set_frame, set_parity;

  assign rx_sample   = (rx_cnt_reg == CNT_W'(CPB - 1));
  assign rx_push     = (rx_state_reg == S_STOP) && rx_sample && rx_sync_reg;
  assign set_overrun = rx_push && rx_full && !rx_ready;
  assign set_frame   = (rx_state_reg == S_STOP) && rx_sample && !rx_sync_reg;
  assign set_parity  = (rx_state_reg == S_PARITY) && rx_sample &&
                       (((^rx_shift_reg) ^ PAR_INV) != rx_sync_reg);
  assign rx_valid    = !rx_empty;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(sysclk), .srst(reset), .push_data(rx_shift_reg), .push(rx_push),
    .pop(rx_ready), .head(rx_data), .full(rx_full), .empty(rx_empty)
  );

  // Two-stage synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= UART_RX;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // RX frame sequencer: validate the start bit at half a bit, then sample each bit centre
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_state_reg <= S_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      case (rx_state_reg)
        S_IDLE: begin
          rx_cnt_reg <= '0;
          if (rx_prev_reg && !rx_sync_reg) rx_state_reg <= S_START;
        end
        S_START: begin
          if (rx_cnt_reg == CNT_W'(HALF - 1)) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rx_sync_reg ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (rx_sample) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_bit_reg == 4'(DATA_BITS - 1)) begin
              rx_state_reg <= HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + 4'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (rx_sample) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= S_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (rx_sample) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= rx_sync_reg ? S_IDLE : S_WAIT_IDLE;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (rx_sync_reg) rx_state_reg <= S_IDLE;
        end
        default: rx_state_reg <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_overrun    <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_overrun    <= (rx_overrun    && !err_clear) || set_overrun;
      rx_frame_err  <= (rx_frame_err  && !err_clear) || set_frame;
      rx_parity_err <= (rx_parity_err && !err_clear) || set_parity;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
module tb_uart_core;

  localparam int CPB = 16;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic       reset;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Drivers, index 0 = dut_a (8N1), 1 = dut_b (8E1), 2 = dut_c (7O2)
  logic [2:0] rx_drv;
  logic [2:0] tx_vld;
  logic [2:0] rx_rdy;
  logic [2:0] err_clr;
  logic [8:0] tx_dat [3];
  logic       loop_a;

  logic       uart_tx_a, uart_tx_b, uart_tx_c;
  logic       tx_ready_a, tx_ready_b, tx_ready_c;
  logic [7:0] rx_data_a, rx_data_b;
  logic [6:0] rx_data_c;
  logic       rx_valid_a, rx_valid_b, rx_valid_c;
  logic       tx_busy_a, tx_busy_b, tx_busy_c;
  logic       ovr_a, ovr_b, ovr_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       perr_a, perr_b, perr_c;

  logic [2:0] tx_line, tx_rdy, tx_bsy, rx_vld, ovr, ferr, perr;
  logic [8:0] rx_dat [3];
  assign tx_line = {uart_tx_c, uart_tx_b, uart_tx_a};
  assign tx_rdy  = {tx_ready_c, tx_ready_b, tx_ready_a};
  assign tx_bsy  = {tx_busy_c, tx_busy_b, tx_busy_a};
  assign rx_vld  = {rx_valid_c, rx_valid_b, rx_valid_a};
  assign ovr     = {ovr_c, ovr_b, ovr_a};
  assign ferr    = {ferr_c, ferr_b, ferr_a};
  assign perr    = {perr_c, perr_b, perr_a};
  assign rx_dat[0] = {1'b0, rx_data_a};
  assign rx_dat[1] = {1'b0, rx_data_b};
  assign rx_dat[2] = {2'b00, rx_data_c};

  uart_core #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
              .TX_DEPTH(4), .RX_DEPTH(4)) dut_a (
    .sysclk(sysclk), .reset(reset), .UART_RX(loop_a ? uart_tx_a : rx_drv[0]), .UART_TX(uart_tx_a),
    .tx_data(tx_dat[0][7:0]), .tx_valid(tx_vld[0]), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_rdy[0]), .tx_busy(tx_busy_a),
    .rx_overrun(ovr_a), .rx_frame_err(ferr_a), .rx_parity_err(perr_a), .err_clear(err_clr[0])
  );

  uart_core #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
              .TX_DEPTH(4), .RX_DEPTH(4)) dut_b (
    .sysclk(sysclk), .reset(reset), .UART_RX(rx_drv[1]), .UART_TX(uart_tx_b),
    .tx_data(tx_dat[1][7:0]), .tx_valid(tx_vld[1]), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_rdy[1]), .tx_busy(tx_busy_b),
    .rx_overrun(ovr_b), .rx_frame_err(ferr_b), .rx_parity_err(perr_b), .err_clear(err_clr[1])
  );

  uart_core #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
              .TX_DEPTH(4), .RX_DEPTH(4)) dut_c (
    .sysclk(sysclk), .reset(reset), .UART_RX(uart_tx_c), .UART_TX(uart_tx_c),
    .tx_data(tx_dat[2][6:0]), .tx_valid(tx_vld[2]), .tx_ready(tx_ready_c),
    .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(rx_rdy[2]), .tx_busy(tx_busy_c),
    .rx_overrun(ovr_c), .rx_frame_err(ferr_c), .rx_parity_err(perr_c), .err_clear(err_clr[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: line bits in transmission order (start, data LSB first, parity, stops)
  function automatic logic [15:0] frame_bits(input int db, input int par, input int sb,
                                             input logic [8:0] d, output int n);
    int          ones;
    logic [15:0] b;
    b = '1; n = 0; ones = 0;
    b[n] = 1'b0; n++;
    for (int i = 0; i < db; i++) begin
      b[n] = d[i];
      if (d[i]) ones++;
      n++;
    end
    if (par != 0) begin
      b[n] = ((ones % 2) == 1) ^ (par == 2);
      n++;
    end
    for (int i = 0; i < sb; i++) begin
      b[n] = 1'b1;
      n++;
    end
    return b;
  endfunction

  task automatic cfg(input int w, output int db, output int par, output int sb);
    case (w)
      0:       begin db = 8; par = 0; sb = 1; end
      1:       begin db = 8; par = 1; sb = 1; end
      default: begin db = 7; par = 2; sb = 2; end
    endcase
  endtask

  task automatic push(input int w, input logic [8:0] d);
    bit ok;
    int guard;
    @(negedge sysclk);
    tx_dat[w] = d;
    tx_vld[w] = 1'b1;
    guard = 0;
    do begin
      ok = tx_rdy[w];
      @(posedge sysclk);
      guard++;
    end while (!ok && guard < 2000);
    #1 tx_vld[w] = 1'b0;
    check("push_ready", {31'd0, ok}, 32'd1);
    $display("[TB] push dut%0d 0x%0h", w, d);
  endtask

  task automatic pop(input int w, output logic [8:0] d, output bit ok);
    int guard;
    guard = 0;
    @(negedge sysclk);
    while (!rx_vld[w] && guard < 3000) begin
      @(negedge sysclk);
      guard++;
    end
    ok = rx_vld[w];
    d  = rx_dat[w];
    rx_rdy[w] = ok;
    @(posedge sysclk);
    #1 rx_rdy[w] = 1'b0;
    $display("[TB] pop dut%0d 0x%0h", w, d);
  endtask

  task automatic drive_bits(input int w, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      rx_drv[w] = b[i];
      repeat (CPB - 1) @(negedge sysclk);
    end
    @(negedge sysclk);
    rx_drv[w] = 1'b1;
    $display("[TB] rx frame dut%0d bits 0x%0h n=%0d", w, b, n);
  endtask

  task automatic pulse_clear(input int w);
    @(negedge sysclk);
    err_clr[w] = 1'b1;
    @(posedge sysclk);
    #1 err_clr[w] = 1'b0;
    @(negedge sysclk);
  endtask

  // Follows nf frames on a TX line starting at its first low cycle; must be called on a negedge
  task automatic mon_tx(input int w, input logic [8:0] data [4], input int nf);
    int          db, par, sb, n, guard;
    logic [15:0] b;
    cfg(w, db, par, sb);
    guard = 0;
    while (tx_line[w] !== 1'b0 && guard < 500) begin
      @(negedge sysclk);
      guard++;
    end
    check("tx_start", {31'd0, tx_line[w]}, 32'd0);
    for (int f = 0; f < nf; f++) begin
      b = frame_bits(db, par, sb, data[f], n);
      for (int i = 0; i < n * CPB; i++) begin
        if (i % CPB == CPB / 2) check("tx_bit", {31'd0, tx_line[w]}, {31'd0, b[i / CPB]});
        if (i == n * CPB - 1) check("tx_busy_end", {31'd0, tx_bsy[w]}, 32'd1);
        @(negedge sysclk);
      end
      if (f < nf - 1) begin
        check("tx_contig", {31'd0, tx_line[w]}, 32'd0);
      end else begin
        check("tx_idle", {31'd0, tx_line[w]}, 32'd1);
        check("tx_len", {31'd0, tx_bsy[w]}, 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  frm [4];
    logic [8:0]  d;
    logic [8:0]  exp_d;
    logic [15:0] b;
    logic [8:0]  exp_q [$];
    int          n, rcv, guard;
    bit          ok;

    reset   = 1'b1;
    rx_drv  = 3'b111;
    tx_vld  = '0;
    rx_rdy  = '0;
    err_clr = '0;
    loop_a  = 1'b0;
    for (int i = 0; i < 3; i++) tx_dat[i] = '0;
    repeat (5) @(posedge sysclk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge sysclk);
    check("rst_tx_line", {29'd0, tx_line}, 32'h7);
    check("rst_tx_ready", {29'd0, tx_rdy}, 32'h7);
    check("rst_rx_valid", {29'd0, rx_vld}, 32'h0);
    check("rst_rx_data", {23'd0, rx_dat[0]}, 32'h0);
    check("rst_tx_busy", {29'd0, tx_bsy}, 32'h0);
    check("rst_flags", {23'd0, ovr, ferr, perr}, 32'h0);

    // Loopback of four back-to-back bytes on the 8N1 core
    loop_a = 1'b1;
    frm = '{9'h0A5, 9'h03C, 9'h0FF, 9'h000};
    fork
      begin
        for (int k = 0; k < 4; k++) push(0, frm[k]);
      end
      begin
        @(negedge sysclk);
        mon_tx(0, frm, 4);
      end
    join
    repeat (40) @(negedge sysclk);
    for (int k = 0; k < 4; k++) begin
      pop(0, d, ok);
      check("loop_avail", {31'd0, ok}, 32'd1);
      check("loop_data", {23'd0, d}, {23'd0, frm[k]});
    end
    check("loop_flags", {29'd0, ovr[0], ferr[0], perr[0]}, 32'd0);
    check("loop_empty", {31'd0, rx_vld[0]}, 32'd0);

    // Even parity: transmitted parity bit, then injected bad parity
    frm[0] = 9'h007;
    fork
      push(1, 9'h007);
      begin
        @(negedge sysclk);
        mon_tx(1, frm, 1);
      end
    join
    b = frame_bits(8, 1, 1, 9'h007, n);
    b[9] = ~b[9];
    drive_bits(1, b, n);
    repeat (20) @(negedge sysclk);
    check("par_valid", {31'd0, rx_vld[1]}, 32'd1);
    check("par_data", {23'd0, rx_dat[1]}, 32'h07);
    check("par_err", {31'd0, perr[1]}, 32'd1);
    check("par_ferr", {31'd0, ferr[1]}, 32'd0);
    pop(1, d, ok);
    pulse_clear(1);
    check("par_clear", {31'd0, perr[1]}, 32'd0);

    // False start then a frame with a low stop bit on the 8N1 core
    loop_a = 1'b0;
    @(negedge sysclk);
    rx_drv[0] = 1'b0;
    repeat (5) @(negedge sysclk);
    rx_drv[0] = 1'b1;
    repeat (40) @(negedge sysclk);
    check("false_start_valid", {31'd0, rx_vld[0]}, 32'd0);
    check("false_start_ferr", {31'd0, ferr[0]}, 32'd0);
    b = frame_bits(8, 0, 1, 9'h055, n);
    b[n - 1] = 1'b0;
    drive_bits(0, b, n);
    repeat (20) @(negedge sysclk);
    check("frame_err", {31'd0, ferr[0]}, 32'd1);
    check("frame_err_valid", {31'd0, rx_vld[0]}, 32'd0);
    pulse_clear(0);
    check("frame_err_clear", {31'd0, ferr[0]}, 32'd0);

    // Overrun: five frames into a four-entry RX FIFO with no pops
    for (int k = 1; k <= 5; k++) begin
      b = frame_bits(8, 0, 1, 9'(k), n);
      drive_bits(0, b, n);
      if (k == 4) check("ovr_before", {31'd0, ovr[0]}, 32'd0);
    end
    repeat (20) @(negedge sysclk);
    check("ovr_set", {31'd0, ovr[0]}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      pop(0, d, ok);
      check("ovr_data", {23'd0, d}, k);
    end
    @(negedge sysclk);
    check("ovr_drained", {31'd0, rx_vld[0]}, 32'd0);
    pulse_clear(0);
    check("ovr_clear", {31'd0, ovr[0]}, 32'd0);

    // Reset during the DATA phase of 0x81, then a clean frame
    push(0, 9'h081);
    repeat (CPB + 40) @(negedge sysclk);
    check("mid_busy", {31'd0, tx_bsy[0]}, 32'd1);
    reset = 1'b1;
    @(posedge sysclk);
    #1 reset = 1'b0;
    @(negedge sysclk);
    check("rst_mid_line", {31'd0, tx_line[0]}, 32'd1);
    check("rst_mid_ready", {31'd0, tx_rdy[0]}, 32'd1);
    check("rst_mid_busy", {31'd0, tx_bsy[0]}, 32'd0);
    push(0, 9'h042);
    @(negedge sysclk);
    check("lat_cycle1", {31'd0, tx_line[0]}, 32'd1);
    @(negedge sysclk);
    check("lat_cycle2", {31'd0, tx_line[0]}, 32'd0);
    frm[0] = 9'h042;
    mon_tx(0, frm, 1);

    // 7 data bits, odd parity, 2 stop bits loopback
    frm[0] = 9'h05A;
    fork
      push(2, 9'h05A);
      begin
        @(negedge sysclk);
        mon_tx(2, frm, 1);
      end
    join
    pop(2, d, ok);
    check("c_avail", {31'd0, ok}, 32'd1);
    check("c_data", {23'd0, d}, 32'h5A);
    check("c_flags", {29'd0, ovr[2], ferr[2], perr[2]}, 32'd0);

    // Randomised loopback traffic with random gaps and random pop acceptance
    loop_a = 1'b1;
    rcv = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          d = 9'($urandom_range(0, 255));
          exp_q.push_back(d);
          push(0, d);
          repeat ($urandom_range(0, 200)) @(negedge sysclk);
        end
      end
      begin
        guard = 0;
        while (rcv < 8 && guard < 30000) begin
          @(negedge sysclk);
          guard++;
          if (rx_vld[0] && $urandom_range(0, 1) != 0) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
            check("rand_data", {23'd0, rx_dat[0]}, {23'd0, exp_d});
            $display("[TB] pop dut0 0x%0h", rx_dat[0]);
            rcv++;
            rx_rdy[0] = 1'b1;
            @(posedge sysclk);
            #1 rx_rdy[0] = 1'b0;
          end
        end
        check("rand_count", rcv, 32'd8);
      end
    join
    repeat (5) @(negedge sysclk);
    check("rand_flags", {29'd0, ovr[0], ferr[0], perr[0]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
